// File: rtl/seq_divider_16bit.sv
// seq_divider_16bit: multi-cycle restoring divider, one quotient bit per clock.
// Operands enter through a valid/ready handshake. Quotient, remainder and a
// divide-by-zero flag leave through a second valid/ready handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands. Magnitudes are
// taken at accept, the unsigned core runs unchanged, and signs are applied on
// the last iteration. Without the macro the block is unsigned only.
//
// Handshake rule for both ports: a transfer happens on a rising clk edge where
// valid && ready are both 1. in_ready and out_valid are decoded from the state
// register only and never depend combinationally on any input. A source holds
// its payload stable while valid=1 and ready=0.
module seq_divider_16bit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [CNT_W-1:0] ITER_CNT = CNT_W'(WIDTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shift register, MSB first
    logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor (magnitude in signed mode)
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // One restoring step. The partial remainder keeps its own MSB when it is
    // shifted: with a large divisor the shifted value can need WIDTH+1 bits.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic qneg_q, qneg_d;   // quotient negative: operand signs differ
    logic rneg_q, rneg_d;   // remainder negative: dividend negative
`endif

    // Restoring-division step and operand conditioning at accept
    always_comb begin
        shifted  = {rem_q, dvd_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_q};
        borrow   = trial[WIDTH];
        rem_step = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], ~borrow};
`ifdef SEQ_DIVIDER_SIGNED_EN
        op_a = dividend[WIDTH-1] ? (~dividend + ONE_W) : dividend;
        op_b = divisor[WIDTH-1]  ? (~divisor + ONE_W)  : divisor;
`else
        op_a = dividend;
        op_b = divisor;
`endif
    end

    // Next-state, datapath next values and handshake outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d = op_a;
                    dvs_d = op_b;
`ifdef SEQ_DIVIDER_SIGNED_EN
                    qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    rneg_d = dividend[WIDTH-1];
`endif
                    if (divisor == '0) begin
                        // Zero divisor skips the iterations entirely.
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                        cnt_d   = ITER_CNT;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    // Unreachable in normal operation; escape rather than hang.
                    state_d = DONE;
                end else begin
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q - ONE_C;
                    quo_d = quo_step;
                    rem_d = rem_step;
                    if (cnt_q == ONE_C) begin
                        state_d = DONE;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        // Signs are applied as the final bit lands.
                        if (qneg_q) quo_d = ~quo_step + ONE_W;
                        if (rneg_q) rem_d = ~rem_step + ONE_W;
`endif
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    dbz_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: counter, operands, quotient, remainder, flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dbz_q  <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_divider_16bit.sv
// Testbench for seq_divider_16bit: directed cases plus randomized operands,
// checked by a scoreboard fed from a plain-arithmetic reference model.
module tb_seq_divider_16bit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    seq_divider_16bit dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Clock and edge counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // Expected {div_by_zero, quotient, remainder}, accept edge, expected latency
    logic [2*W:0] exp_q[$];
    int           acc_q[$];
    int           lat_q[$];
    bit           rand_rdy = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model straight from the arithmetic definition
    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] q;
        logic [63:0] r;
        if (b == '0) return {1'b1, {W{1'b1}}, a};
`ifdef SEQ_DIVIDER_SIGNED_EN
        q = 64'(longint'($signed(a)) / longint'($signed(b)));
        r = 64'(longint'($signed(a)) % longint'($signed(b)));
`else
        q = 64'(a) / 64'(b);
        r = 64'(a) % 64'(b);
`endif
        return {1'b0, q[W-1:0], r[W-1:0]};
    endfunction

    // Driver: wait for in_ready, present one pair, log expectation at accept
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1);
            return;
        end
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(model(a, b));
        acc_q.push_back(cyc);
        lat_q.push_back((b == '0) ? 1 : W + 1);
        in_valid = 1'b0;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #2;
        out_ready = v;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
            acc_q.delete();
            lat_q.delete();
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check("valid_timeout", out_valid, 1);
    endtask

    // Random backpressure on out_ready, changed just after each edge
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor / scoreboard: latency on first valid, hold stability, result at handoff
    bit           first = 1'b1;
    logic [W-1:0] hq, hr;
    logic         hz;
    logic [2*W:0] e;
    always @(negedge clk) begin
        if (!rstn) begin
            first = 1'b1;
        end else if (out_valid) begin
            if (first) begin
                first = 1'b0;
                hq = quotient;
                hr = remainder;
                hz = div_by_zero;
                if (exp_q.size() == 0) check("unexpected_valid", out_valid, 0);
                else check("latency", cyc - acc_q[0] + 1, lat_q[0]);
            end else begin
                check("hold_quotient", quotient, hq);
                check("hold_remainder", remainder, hr);
                check("hold_dbz", div_by_zero, hz);
            end
            if (out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                void'(acc_q.pop_front());
                void'(lat_q.pop_front());
                check("quotient", quotient, e[2*W-1:W]);
                check("remainder", remainder, e[W-1:0]);
                check("div_by_zero", div_by_zero, e[2*W]);
                first = 1'b1;
            end
        end
    end

    initial begin
        logic [W-1:0] a, b;

        // Reset, then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);

        set_ready(1'b1);
        send(16'h0064, 16'h0007);
        drain();

        send(16'h1234, 16'h0000);
        drain();
        @(negedge clk);
        check("dbz_cleared", div_by_zero, 0);
        check("idle_in_ready", in_ready, 1);
        check("quotient_kept", quotient, 16'hFFFF);

        // Backpressure: result held, in_ready low, stray in_valid ignored
        set_ready(1'b0);
        send(16'hFFFF, 16'h0001);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            dividend = 16'h5555;
            divisor  = 16'h0002;
            check("busy_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        set_ready(1'b1);
        drain();
        @(negedge clk);
        check("release_in_ready", in_ready, 1);
        check("release_out_valid", out_valid, 0);

        // Reset in the middle of CALC
        send(16'h8000, 16'h0003);
        repeat (8) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_dbz", div_by_zero, 0);
        exp_q.delete();
        acc_q.delete();
        lat_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        send(16'h000A, 16'h0003);
        drain();

`ifdef SEQ_DIVIDER_SIGNED_EN
        send(16'hFFF9, 16'h0002);
        send(16'h8000, 16'hFFFF);
        drain();
`endif

        // Randomized operands with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                default: b = W'($urandom);
            endcase
            send(a, b);
        end
        drain();
        rand_rdy = 1'b0;
        set_ready(1'b1);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
